// File: rtl/sp_ram_req_ctrl_if.sv
// Request/response handshake bundle for sp_ram_req_ctrl.
// master: client (drives req_*, rsp_ready); slave: controller.
interface sp_ram_req_ctrl_if #(
   parameter int AW = 5,
   parameter int DW = 4
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sp_ram_req_ctrl.sv
// Request front-end for a single-port registered-input RAM with in-order
// read responses through a credit-limited response FIFO.
// Ports: clk, rst (sync, active-high); bus (slave: req_valid/ready/we/
// addr/wdata, rsp_valid/ready/rdata); init_done; ram_we/addr/din out,
// ram_dout in. Define SP_RAM_CTRL_INIT_EN to zero-fill the RAM after reset.
module sp_ram_req_ctrl #(
   parameter int AW        = 5,
   parameter int DW        = 4,
   parameter int RD_LAT    = 2,
   parameter int RSP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   sp_ram_req_ctrl_if.slave bus,
   output logic             init_done,
   output logic             ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [DW-1:0]    ram_din,
   input  logic [DW-1:0]    ram_dout
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int OW = $clog2(RSP_DEPTH + RD_LAT + 1);

   logic          run;
   logic          init_act;
   logic [AW-1:0] init_ram_addr;

`ifdef SP_RAM_CTRL_INIT_EN
   typedef enum logic {INIT, RUN} state_t;
   localparam logic [AW:0] A_ONE = 1;

   state_t      state_q, state_d;
   logic [AW:0] init_addr_q, init_addr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   // Extra counter bit flags the terminal count without wrapping.
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      unique case (state_q)
         INIT: begin
            init_addr_d = init_addr_q + A_ONE;
            if (init_addr_d[AW])
               state_d = RUN;
         end
         RUN: ;
      endcase
   end

   assign run           = (state_q == RUN);
   assign init_act      = (state_q == INIT);
   assign init_ram_addr = init_addr_q[AW-1:0];
`else
   assign run           = 1'b1;
   assign init_act      = 1'b0;
   assign init_ram_addr = '0;
`endif

   assign init_done = run;

   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     count_q;
   logic [OW-1:0]     outstanding;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     din_q;
   logic [DW-1:0]     fifo_mem [RSP_DEPTH];
   logic              fire, push, pop;

   // Credits cover both reads in the RAM pipe and those in the FIFO.
   always_comb begin
      outstanding = OW'(count_q);
      for (int i = 0; i < RD_LAT; i++)
         outstanding = outstanding + OW'(pipe_q[i]);
   end

   assign bus.req_ready = !rst && run
                        && (outstanding < OW'(RSP_DEPTH));
   assign fire = bus.req_valid && bus.req_ready;
   assign push = pipe_q[RD_LAT-1];
   assign pop  = bus.rsp_valid && bus.rsp_ready;

   // The RAM registers its inputs, so a combinational mux is safe here.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = addr_q;
      ram_din  = din_q;
      if (rst) begin
         ram_addr = '0;
         ram_din  = '0;
      end else if (init_act) begin
         ram_we   = 1'b1;
         ram_addr = init_ram_addr;
         ram_din  = '0;
      end else if (fire) begin
         ram_we   = bus.req_we;
         ram_addr = bus.req_addr;
         ram_din  = bus.req_wdata;
      end
   end

   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = fire && !bus.req_we;
      for (int i = 1; i < RD_LAT; i++)
         pipe_d[i] = pipe_q[i-1];
   end

   function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
         din_q    <= '0;
      end else begin
         pipe_q <= pipe_d;
         addr_q <= ram_addr;
         din_q  <= ram_din;
         if (push)
            wr_ptr_q <= nxt_ptr(wr_ptr_q);
         if (pop)
            rd_ptr_q <= nxt_ptr(rd_ptr_q);
         if (push && !pop)
            count_q <= count_q + CW'(1);
         else if (!push && pop)
            count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_q] <= ram_dout;
   end

   assign bus.rsp_valid = (count_q != '0);
   assign bus.rsp_rdata = bus.rsp_valid ? fifo_mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Directed bench for sp_ram_req_ctrl with a RAM model and response
// scoreboard; init-fill steps follow SP_RAM_CTRL_INIT_EN.
module tb_sp_ram_req_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       init_done;
   logic       ram_we;
   logic [4:0] ram_addr;
   logic [3:0] ram_din;
   logic [3:0] ram_dout;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [3:0] mem     [32];
   logic [3:0] ref_mem [32];
   logic [4:0] ram_addr_q;
   logic [3:0] sb [$];

   always #5 clk = ~clk;

   sp_ram_req_ctrl_if #(.AW(5), .DW(4)) bus ();

   sp_ram_req_ctrl #(
      .AW(5), .DW(4), .RD_LAT(2), .RSP_DEPTH(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .init_done(init_done),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   // Registered-input RAM, two cycles from address to dout.
   always @(posedge clk) begin
      if (ram_we)
         mem[ram_addr] <= ram_din;
      ram_addr_q <= ram_addr;
      ram_dout   <= mem[ram_addr_q];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: reference memory tracks writes, reads push expectations.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
`ifdef SP_RAM_CTRL_INIT_EN
         foreach (ref_mem[i]) ref_mem[i] = '0;
`endif
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            if (bus.req_we)
               ref_mem[bus.req_addr] = bus.req_wdata;
            else
               sb.push_back(ref_mem[bus.req_addr]);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0)
               chk("rsp_spurious", 32'(bus.rsp_valid), 32'd0);
            else
               chk("rsp_data", 32'(bus.rsp_rdata), 32'(sb.pop_front()));
         end
      end
   end

   task automatic do_req(input logic we, input logic [4:0] a,
                         input logic [3:0] d);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         n++;
      end
      chk("req_accept", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      @(negedge clk);
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((sb.size() != 0 || bus.rsp_valid) && n < 50);
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

`ifdef SP_RAM_CTRL_INIT_EN
   task automatic init_check();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("init_we", 32'(ram_we), 32'd1);
         chk("init_addr", 32'(ram_addr), 32'(i));
         chk("init_din", 32'(ram_din), 32'd0);
         chk("init_rdy", 32'(bus.req_ready), 32'd0);
         chk("init_done_lo", 32'(init_done), 32'd0);
         chk("init_rsp", 32'(bus.rsp_valid), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("init_done_hi", 32'(init_done), 32'd1);
      chk("run_rdy", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      foreach (mem[i]) mem[i] = '0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int nxt;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_din", 32'(ram_din), 32'd0);
`ifdef SP_RAM_CTRL_INIT_EN
      chk("rst_init_done", 32'(init_done), 32'd0);
`else
      chk("rst_init_done", 32'(init_done), 32'd1);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

`ifdef SP_RAM_CTRL_INIT_EN
      init_check();
`else
      @(negedge clk);
      chk("run_init_done", 32'(init_done), 32'd1);
      chk("run_rdy", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
`endif

      // Write then immediate read-back, latency check.
      do_req(1'b1, 5'd3, 4'hA);
      do_req(1'b0, 5'd3, 4'h0);
      wait_rsp(lat);
      chk("raw_latency", 32'(lat), 32'd3);
      chk("raw_data", 32'(bus.rsp_rdata), 32'hA);
      drain();

      // Unwritten address reads zero.
      do_req(1'b0, 5'd17, 4'h0);
      wait_rsp(lat);
      chk("rd17_latency", 32'(lat), 32'd3);
      chk("rd17_data", 32'(bus.rsp_rdata), 32'h0);
      drain();

      // Backpressure: credits stop acceptance at four reads.
      for (int i = 0; i < 6; i++)
         do_req(1'b1, 5'(i), 4'(i + 5));
      bus.rsp_ready = 1'b0;
      nxt = 0;
      for (int c = 0; c < 6; c++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b0;
         bus.req_addr  = 5'(nxt);
         @(negedge clk);
         if (bus.req_ready)
            nxt++;
         @(posedge clk); #1;
      end
      chk("bp_accepted", 32'(nxt), 32'd4);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_rdy_low", 32'(bus.req_ready), 32'd0);
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_rsp_hold", 32'(bus.rsp_rdata), 32'd5);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_rdy_pop_cyc", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_rdy_back", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      do_req(1'b0, 5'd5, 4'h0);
      drain();

      // Alternating write/read to one address, no stalls.
      for (int k = 0; k < 6; k++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = (k % 2 == 0);
         bus.req_addr  = 5'd9;
         bus.req_wdata = 4'(k / 2 + 1);
         @(negedge clk);
         chk("alt_rdy", 32'(bus.req_ready), 32'd1);
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      drain();

      // Reset with one FIFO entry and two reads in flight.
      bus.rsp_ready = 1'b0;
      do_req(1'b0, 5'd1, 4'h0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      do_req(1'b0, 5'd2, 4'h0);
      do_req(1'b0, 5'd4, 4'h0);
      @(negedge clk);
      chk("mid_fifo_valid", 32'(bus.rsp_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
`ifdef SP_RAM_CTRL_INIT_EN
      init_check();
`else
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
         chk("rst_run_rdy", 32'(bus.req_ready), 32'd1);
         @(posedge clk); #1;
      end
`endif
      do_req(1'b1, 5'd9, 4'h7);
      do_req(1'b0, 5'd9, 4'h0);
      wait_rsp(lat);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_data", 32'(bus.rsp_rdata), 32'h7);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
